// File: rtl/coeff_token_dec_pipe.sv
// Registered, handshaked CAVLC coeff_token decoder (FLC table, optional chroma DC table).
// Optional chroma DC table decode is enabled by defining CHROMA_DC_EN.
module coeff_token_dec_pipe #(
    parameter int unsigned WIN_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIN_W-1:0] Window,
    input  logic             Mode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [4:0]       TotalCoeff,
    output logic [1:0]       TrailingOnes,
    output logic [4:0]       NumShift,
    output logic             Err,
    output logic             Halted,
    input  logic             Flush,
    output logic [CNT_W-1:0] TokenCount
);

    localparam int unsigned TC_W = 5;
    localparam int unsigned T1_W = 2;
    localparam int unsigned NS_W = 5;

    typedef enum logic {RUN, HALT} state_t;

    state_t state_q, state_d;

    logic            accept;
    logic            take;
    logic [5:0]      flc_code;
    logic [TC_W-1:0] flc_tc;
    logic [T1_W-1:0] flc_t1;
    logic            flc_err;
    logic [TC_W-1:0] cd_tc;
    logic [T1_W-1:0] cd_t1;
    logic [NS_W-1:0] cd_ns;
    logic            cd_err;
    logic [TC_W-1:0] dec_tc;
    logic [T1_W-1:0] dec_t1;
    logic [NS_W-1:0] dec_ns;
    logic            dec_err;
    logic            unused_win;

    // Only the top 6 or 8 window bits are ever decoded.
    assign unused_win = ^Window;

    assign InReady = (state_q == RUN) && (!OutValid || OutReady);
    assign Halted  = (state_q == HALT);
    assign accept  = InValid && InReady;
    assign take    = OutValid && OutReady;

    // FLC table: 4-bit TC-1 followed by 2-bit T1, with 000011 reserved for TC=0.
    assign flc_code = Window[WIN_W-1 -: 6];

    always_comb begin
        flc_tc  = TC_W'(flc_code[5:2]) + TC_W'(1);
        flc_t1  = flc_code[1:0];
        if (flc_code == 6'b000011) begin
            flc_tc = '0;
            flc_t1 = '0;
        end
        flc_err = TC_W'(flc_t1) > flc_tc;
    end

`ifdef CHROMA_DC_EN
    logic [7:0] cd_code;
    assign cd_code = Window[WIN_W-1 -: 8];

    // Chroma DC VLC; 00000001 is the one unassigned 8-bit prefix.
    always_comb begin
        cd_tc  = '0;
        cd_t1  = '0;
        cd_ns  = '0;
        cd_err = 1'b0;
        casez (cd_code)
            8'b1???????: begin cd_t1 = 2'd1; cd_tc = 5'd1; cd_ns = 5'd1; end
            8'b01??????: begin cd_t1 = 2'd0; cd_tc = 5'd0; cd_ns = 5'd2; end
            8'b001?????: begin cd_t1 = 2'd2; cd_tc = 5'd2; cd_ns = 5'd3; end
            8'b000111??: begin cd_t1 = 2'd0; cd_tc = 5'd1; cd_ns = 5'd6; end
            8'b000100??: begin cd_t1 = 2'd0; cd_tc = 5'd2; cd_ns = 5'd6; end
            8'b000110??: begin cd_t1 = 2'd1; cd_tc = 5'd2; cd_ns = 5'd6; end
            8'b000011??: begin cd_t1 = 2'd0; cd_tc = 5'd3; cd_ns = 5'd6; end
            8'b000101??: begin cd_t1 = 2'd3; cd_tc = 5'd3; cd_ns = 5'd6; end
            8'b000010??: begin cd_t1 = 2'd0; cd_tc = 5'd4; cd_ns = 5'd6; end
            8'b0000011?: begin cd_t1 = 2'd1; cd_tc = 5'd3; cd_ns = 5'd7; end
            8'b0000010?: begin cd_t1 = 2'd2; cd_tc = 5'd3; cd_ns = 5'd7; end
            8'b00000011: begin cd_t1 = 2'd1; cd_tc = 5'd4; cd_ns = 5'd8; end
            8'b00000010: begin cd_t1 = 2'd2; cd_tc = 5'd4; cd_ns = 5'd8; end
            8'b00000000: begin cd_t1 = 2'd3; cd_tc = 5'd4; cd_ns = 5'd7; end
            default:     cd_err = 1'b1;
        endcase
    end
`else
    assign cd_tc  = '0;
    assign cd_t1  = '0;
    assign cd_ns  = '0;
    assign cd_err = 1'b1;
`endif

    // Table select; any invalid code collapses to the fixed error token.
    always_comb begin
        dec_tc  = Mode ? cd_tc  : flc_tc;
        dec_t1  = Mode ? cd_t1  : flc_t1;
        dec_ns  = Mode ? cd_ns  : NS_W'(6);
        dec_err = Mode ? cd_err : flc_err;
        if (dec_err) begin
            dec_tc = TC_W'(31);
            dec_t1 = '0;
            dec_ns = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && dec_err) state_d = HALT;
            HALT:    if (Flush)             state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output register: flush beats accept (accept cannot occur in HALT anyway).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            OutValid     <= 1'b0;
            TotalCoeff   <= '0;
            TrailingOnes <= '0;
            NumShift     <= '0;
            Err          <= 1'b0;
            TokenCount   <= '0;
        end else begin
            if (take && !Err) TokenCount <= TokenCount + CNT_W'(1);
            if (state_q == HALT && Flush) begin
                OutValid <= 1'b0;
            end else if (accept) begin
                OutValid     <= 1'b1;
                TotalCoeff   <= dec_tc;
                TrailingOnes <= dec_t1;
                NumShift     <= dec_ns;
                Err          <= dec_err;
            end else if (take) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_coeff_token_dec_pipe.sv
// Scoreboard bench for coeff_token_dec_pipe; expectations follow CHROMA_DC_EN when defined.
module tb_coeff_token_dec_pipe;

    localparam int unsigned WIN_W = 16;
    localparam int unsigned CNT_W = 4;

    logic             Clk;
    logic             Reset;
    logic             InValid;
    logic             InReady;
    logic [WIN_W-1:0] Window;
    logic             Mode;
    logic             OutValid;
    logic             OutReady;
    logic [4:0]       TotalCoeff;
    logic [1:0]       TrailingOnes;
    logic [4:0]       NumShift;
    logic             Err;
    logic             Halted;
    logic             Flush;
    logic [CNT_W-1:0] TokenCount;

    coeff_token_dec_pipe #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Window(Window), .Mode(Mode), .OutValid(OutValid), .OutReady(OutReady),
        .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes), .NumShift(NumShift),
        .Err(Err), .Halted(Halted), .Flush(Flush), .TokenCount(TokenCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [12:0]      exp_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             prev_stall = 1'b0;
    logic [12:0]      prev_out = '0;
    logic             rdy_toggle = 1'b0;

    function automatic logic [12:0] pk(int tc, int t1, int ns, bit e);
        return {e, 5'(tc), 2'(t1), 5'(ns)};
    endfunction

    localparam logic [12:0] ERR_V = {1'b1, 5'd31, 2'd0, 5'd0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops on every hand-off (or flush drop) and tracks the token counter.
    always @(negedge Clk) begin
        logic [12:0] cur;
        logic [12:0] e;
        cur = {Err, TotalCoeff, TrailingOnes, NumShift};
        if (Reset) begin
            exp_q.delete();
            exp_cnt    = '0;
            prev_stall = 1'b0;
        end else begin
            check("token_count", 32'(TokenCount), 32'(exp_cnt));
            if (prev_stall) begin
                check("stall_valid", 32'(OutValid), 32'd1);
                check("stall_hold", 32'(cur), 32'(prev_out));
            end
            if (OutValid && (OutReady || (Flush && Halted))) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none at %0t", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(cur), 32'(e));
                    if (OutReady && !Err) exp_cnt = exp_cnt + CNT_W'(1);
                end
            end
            prev_stall = OutValid && !OutReady && !Flush;
            prev_out   = cur;
        end
    end

    initial begin
        forever begin
            @(posedge Clk);
            #2;
            if (rdy_toggle) OutReady = ~OutReady;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send(input logic m, input logic [WIN_W-1:0] w, input logic [12:0] e);
        bit done;
        done    = 1'b0;
        Mode    = m;
        Window  = w;
        InValid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge Clk);
            if (InReady) begin
                exp_q.push_back(e);
                @(posedge Clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=InReady_low required=accept window=%0h", w);
        end
        InValid = 1'b0;
    endtask

    task automatic pulse_flush();
        Flush = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        InValid  = 1'b0;
        Mode     = 1'b0;
        Window   = '0;
        OutReady = 1'b1;
        Flush    = 1'b0;
        idle(2);
        Reset = 1'b0;

        @(negedge Clk);
        check("rst_outvalid", 32'(OutValid), 32'd0);
        check("rst_inready", 32'(InReady), 32'd1);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_fields", 32'({Err, TotalCoeff, TrailingOnes, NumShift}), 32'd0);
        idle(1);

        // FLC basic decode
        send(1'b0, 16'h3C00, pk(4, 3, 6, 0));
        idle(2);

        // TC=0 code followed by an invalid code, held under stall, then flushed
        send(1'b0, 16'h0C00, pk(0, 0, 6, 0));
        send(1'b0, 16'h0800, ERR_V);
        OutReady = 1'b0;
        @(negedge Clk);
        check("err_halted", 32'(Halted), 32'd1);
        check("err_inready", 32'(InReady), 32'd0);
        check("err_outvalid", 32'(OutValid), 32'd1);
        idle(3);
        pulse_flush();
        @(negedge Clk);
        check("flush_halted", 32'(Halted), 32'd0);
        check("flush_outvalid", 32'(OutValid), 32'd0);
        check("flush_inready", 32'(InReady), 32'd1);
        idle(1);

        // Flush in RUN must not drop a pending result
        send(1'b0, 16'h0000, pk(1, 0, 6, 0));
        pulse_flush();
        @(negedge Clk);
        check("run_flush_ignored", 32'(OutValid), 32'd1);
        idle(1);
        OutReady = 1'b1;
        idle(2);

        // Invalid code taken immediately; block stays halted until flush
        send(1'b0, 16'h1C00, ERR_V);
        idle(1);
        @(negedge Clk);
        check("halt_after_take", 32'(Halted), 32'd1);
        check("halt_outvalid", 32'(OutValid), 32'd0);
        check("halt_inready", 32'(InReady), 32'd0);
        idle(1);
        pulse_flush();
        @(negedge Clk);
        check("halt_cleared", 32'(Halted), 32'd0);
        idle(1);

        // Back-to-back with toggling OutReady
        rdy_toggle = 1'b1;
        send(1'b0, 16'hFC00, pk(16, 3, 6, 0));
        send(1'b0, 16'h5400, pk(6, 1, 6, 0));
        send(1'b0, 16'h8000, pk(9, 0, 6, 0));
        send(1'b0, 16'h3C00, pk(4, 3, 6, 0));
        send(1'b0, 16'h0000, pk(1, 0, 6, 0));
        rdy_toggle = 1'b0;
        OutReady   = 1'b1;
        idle(3);

        // Chroma DC table
`ifdef CHROMA_DC_EN
        send(1'b1, 16'h8000, pk(1, 1, 1, 0));
        send(1'b1, 16'h0300, pk(4, 1, 8, 0));
        send(1'b1, 16'h0000, pk(4, 3, 7, 0));
        send(1'b1, 16'h4000, pk(0, 0, 2, 0));
        send(1'b1, 16'h2000, pk(2, 2, 3, 0));
        send(1'b1, 16'h1C00, pk(1, 0, 6, 0));
        send(1'b1, 16'h0600, pk(3, 1, 7, 0));
        send(1'b1, 16'h1400, pk(3, 3, 6, 0));
        send(1'b1, 16'h0100, ERR_V);
`else
        send(1'b1, 16'h8000, ERR_V);
`endif
        @(negedge Clk);
        check("mode1_halted", 32'(Halted), 32'd1);
        idle(1);
        pulse_flush();
        idle(2);

        // Reset mid-stream with a result pending
        OutReady = 1'b0;
        send(1'b0, 16'h3C00, pk(4, 3, 6, 0));
        pulse_reset();
        @(negedge Clk);
        check("mid_rst_outvalid", 32'(OutValid), 32'd0);
        check("mid_rst_fields", 32'({Err, TotalCoeff, TrailingOnes, NumShift}), 32'd0);
        check("mid_rst_count", 32'(TokenCount), 32'd0);
        check("mid_rst_inready", 32'(InReady), 32'd1);
        check("mid_rst_halted", 32'(Halted), 32'd0);
        idle(1);
        OutReady = 1'b1;

        // 16 valid tokens wrap a 4-bit counter; the error token is not counted
        for (int i = 0; i < 8; i++) send(1'b0, 16'h3C00, pk(4, 3, 6, 0));
        send(1'b0, 16'h0800, ERR_V);
        pulse_flush();
        for (int i = 0; i < 8; i++) send(1'b0, 16'h5400, pk(6, 1, 6, 0));
        idle(3);
        @(negedge Clk);
        check("count_wrap", 32'(TokenCount), 32'd0);
        idle(2);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
